// File: rtl/mc_pkg.sv
// Shared definitions for the multicycle MIPS controller: state encoding,
// instruction fields, ALU-operation classes and ALU function codes.
package mc_pkg;

   typedef enum logic [3:0] {
      S_FETCH   = 4'd0,
      S_DECODE  = 4'd1,
      S_MEMADR  = 4'd2,
      S_MEMRD   = 4'd3,
      S_MEMWB   = 4'd4,
      S_MEMWR   = 4'd5,
      S_RTYPEEX = 4'd6,
      S_RTYPEWB = 4'd7,
      S_BEQEX   = 4'd8,
      S_ADDIEX  = 4'd9,
      S_ADDIWB  = 4'd10,
      S_JEX     = 4'd11
   } state_t;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_J     = 6'b000010;

   localparam logic [5:0] FN_ADD = 6'b100000;
   localparam logic [5:0] FN_SUB = 6'b100010;
   localparam logic [5:0] FN_AND = 6'b100100;
   localparam logic [5:0] FN_OR  = 6'b100101;
   localparam logic [5:0] FN_SLT = 6'b101010;

   typedef enum logic [1:0] {
      ADD   = 2'd0,
      SUB   = 2'd1,
      FUNCT = 2'd2
   } aluop_t;

   localparam logic [2:0] ALU_ADD = 3'b010;
   localparam logic [2:0] ALU_SUB = 3'b110;
   localparam logic [2:0] ALU_AND = 3'b000;
   localparam logic [2:0] ALU_OR  = 3'b001;
   localparam logic [2:0] ALU_SLT = 3'b111;

   function automatic logic op_supported(input logic [5:0] op);
      case (op)
         OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J: return 1'b1;
         default:                                      return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/mc_aludec.sv
// ALU decoder: maps the controller's operation class and the R-type funct
// field onto the ALU's 3-bit function select.
module mc_aludec
   import mc_pkg::*;
(
   input  aluop_t     aluop,
   input  logic [5:0] funct,
   output logic [2:0] alucontrol
);

   always_comb begin
      alucontrol = ALU_ADD;
      case (aluop)
         ADD: alucontrol = ALU_ADD;
         SUB: alucontrol = ALU_SUB;
         FUNCT: begin
            // Unknown functs fall back to add so no X reaches the ALU.
            case (funct)
               FN_ADD:  alucontrol = ALU_ADD;
               FN_SUB:  alucontrol = ALU_SUB;
               FN_AND:  alucontrol = ALU_AND;
               FN_OR:   alucontrol = ALU_OR;
               FN_SLT:  alucontrol = ALU_SLT;
               default: alucontrol = ALU_ADD;
            endcase
         end
         default: alucontrol = ALU_ADD;
      endcase
   end

endmodule

// File: rtl/mc_controller.sv
// Multicycle MIPS control unit: Moore FSM sequencing fetch/decode/execute/
// memory/writeback, plus the ALU decoder and the PC enable merge.
module mc_controller
   import mc_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic [5:0] op,
   input  logic [5:0] funct,
   input  logic       zero,
   output logic       iord,
   output logic       memwrite,
   output logic       irwrite,
   output logic       regdst,
   output logic       memtoreg,
   output logic       regwrite,
   output logic       alusrca,
   output logic [1:0] alusrcb,
   output logic [1:0] pcsrc,
   output logic       pcen,
   output logic [2:0] alucontrol,
   output logic       illegal_op,
   output logic [3:0] state_o
);

   state_t r_state;
   state_t w_next;
   aluop_t w_aluop;
   logic   w_pcwrite;
   logic   w_branch;

   always_ff @(posedge clk) begin
      if (reset) r_state <= S_FETCH;
      else       r_state <= w_next;
   end

   always_comb begin
      w_next = S_FETCH;
      case (r_state)
         S_FETCH: w_next = S_DECODE;
         S_DECODE: begin
            case (op)
               OP_LW, OP_SW: w_next = S_MEMADR;
               OP_RTYPE:     w_next = S_RTYPEEX;
               OP_BEQ:       w_next = S_BEQEX;
               OP_ADDI:      w_next = S_ADDIEX;
               OP_J:         w_next = S_JEX;
               default:      w_next = S_FETCH;
            endcase
         end
         S_MEMADR:  w_next = (op == OP_LW) ? S_MEMRD : S_MEMWR;
         S_MEMRD:   w_next = S_MEMWB;
         S_RTYPEEX: w_next = S_RTYPEWB;
         S_ADDIEX:  w_next = S_ADDIWB;
         default:   w_next = S_FETCH;
      endcase
   end

   always_comb begin
      iord       = 1'b0;
      memwrite   = 1'b0;
      irwrite    = 1'b0;
      regdst     = 1'b0;
      memtoreg   = 1'b0;
      regwrite   = 1'b0;
      alusrca    = 1'b0;
      alusrcb    = 2'b00;
      pcsrc      = 2'b00;
      illegal_op = 1'b0;
      w_pcwrite  = 1'b0;
      w_branch   = 1'b0;
      w_aluop    = ADD;
      case (r_state)
         S_FETCH: begin
            irwrite   = 1'b1;
            w_pcwrite = 1'b1;
            alusrcb   = 2'b01;
         end
         S_DECODE: begin
            // Precompute the branch target while the opcode is decoded.
            alusrcb    = 2'b11;
            illegal_op = ~op_supported(op);
         end
         S_MEMADR: begin
            alusrca = 1'b1;
            alusrcb = 2'b10;
         end
         S_MEMRD: iord = 1'b1;
         S_MEMWB: begin
            regwrite = 1'b1;
            memtoreg = 1'b1;
         end
         S_MEMWR: begin
            iord     = 1'b1;
            memwrite = 1'b1;
         end
         S_RTYPEEX: begin
            alusrca = 1'b1;
            w_aluop = FUNCT;
         end
         S_RTYPEWB: begin
            regdst   = 1'b1;
            regwrite = 1'b1;
         end
         S_BEQEX: begin
            alusrca  = 1'b1;
            w_aluop  = SUB;
            w_branch = 1'b1;
            pcsrc    = 2'b01;
         end
         S_ADDIEX: begin
            alusrca = 1'b1;
            alusrcb = 2'b10;
         end
         S_ADDIWB: regwrite = 1'b1;
         S_JEX: begin
            w_pcwrite = 1'b1;
            pcsrc     = 2'b10;
         end
         default: ;
      endcase
   end

   mc_aludec u_aludec (
      .aluop      (w_aluop),
      .funct      (funct),
      .alucontrol (alucontrol)
   );

   // zero reaches pcen only through the branch term.
   assign pcen    = w_pcwrite | (w_branch & zero);
   assign state_o = r_state;

endmodule
